// File: rtl/stand_cell_array.sv
// stand_cell_array: multi-channel clocked model of a discrete logic cell with
// separate high-to-low and low-to-high propagation delays, counted in cycles
// of the sampling clock U. Each channel drives its output towards the target
// T = D ^ INVERT after the delay selected by the direction of the change.
// MODE selects between the legacy two-counter response, which passes short
// pulses through as full-width excursions, and the inertial response, which
// swallows pulses shorter than the delay and records them in GLITCH.

module stand_cell_array #(
    parameter int unsigned      WIDTH  = 8,
    parameter int unsigned      TPHL   = 7,
    parameter int unsigned      TPLH   = 31,
    parameter bit               INVERT = 1'b1,
    parameter bit               MODE   = 1'b1,
    parameter logic [WIDTH-1:0] INIT   = '1
) (
    input  logic             U,
    input  logic             RESET,
    input  logic [WIDTH-1:0] D,
    input  logic             CLRGLITCH,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] BUSY,
    output logic [WIDTH-1:0] GLITCH
);

    // Counters only ever need to reach the larger of the two delays.
    localparam int unsigned MAXD = (TPHL > TPLH) ? TPHL : TPLH;
    localparam int unsigned CW   = ($clog2(MAXD + 1) > 1) ? $clog2(MAXD + 1) : 1;

    localparam logic [CW-1:0] TPHL_C = CW'(TPHL);
    localparam logic [CW-1:0] TPLH_C = CW'(TPLH);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch

        logic t;
        logic q_q, q_d;
        logic glitch_q, glitch_d;

        assign t = D[i] ^ INVERT;

        if (MODE) begin : g_inertial

            logic [CW-1:0] cnt_q, cnt_d;
            logic [CW-1:0] dly;

            assign dly = t ? TPLH_C : TPHL_C;

            // Inertial next state: count while the target differs, commit on
            // saturation, and drop a partial count as a rejected glitch.
            always_comb begin
                q_d      = q_q;
                cnt_d    = cnt_q;
                glitch_d = glitch_q & ~CLRGLITCH;
                if (t == q_q) begin
                    if (cnt_q != '0) begin
                        cnt_d    = '0;
                        glitch_d = 1'b1;
                    end
                end else if (cnt_q != dly) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    q_d   = t;
                    cnt_d = '0;
                end
            end

            // Channel state register with synchronous reset.
            always_ff @(posedge U) begin
                if (RESET) begin
                    q_q      <= INIT[i];
                    cnt_q    <= '0;
                    glitch_q <= 1'b0;
                end else begin
                    q_q      <= q_d;
                    cnt_q    <= cnt_d;
                    glitch_q <= glitch_d;
                end
            end

            assign BUSY[i] = (cnt_q != '0);

        end else begin : g_legacy

            logic [CW-1:0] hc_q, hc_d;
            logic [CW-1:0] lc_q, lc_d;

            // Legacy next state: the active side counter runs up to its delay
            // while Q is forced to the opposite level; the idle side is cleared.
            always_comb begin
                q_d      = q_q;
                hc_d     = hc_q;
                lc_d     = lc_q;
                glitch_d = glitch_q & ~CLRGLITCH;
                if (!t) begin
                    lc_d = '0;
                    if (hc_q != TPHL_C) begin
                        q_d  = 1'b1;
                        hc_d = hc_q + 1'b1;
                    end else begin
                        q_d = 1'b0;
                    end
                end else begin
                    hc_d = '0;
                    if (lc_q != TPLH_C) begin
                        q_d  = 1'b0;
                        lc_d = lc_q + 1'b1;
                    end else begin
                        q_d = 1'b1;
                    end
                end
            end

            // Channel state register with synchronous reset.
            always_ff @(posedge U) begin
                if (RESET) begin
                    q_q      <= INIT[i];
                    hc_q     <= '0;
                    lc_q     <= '0;
                    glitch_q <= 1'b0;
                end else begin
                    q_q      <= q_d;
                    hc_q     <= hc_d;
                    lc_q     <= lc_d;
                    glitch_q <= glitch_d;
                end
            end

            // Only one side is ever non-zero, so the active side is whichever
            // counter has left zero; it stays busy until it saturates.
            assign BUSY[i] = ((hc_q != '0) && (hc_q != TPHL_C)) ||
                             ((lc_q != '0) && (lc_q != TPLH_C));

        end

        assign Q[i]      = q_q;
        assign GLITCH[i] = glitch_q;

    end

endmodule

// File: tb/tb_stand_cell_array.sv
// Testbench for stand_cell_array. Four instances share one stimulus stream:
//   0: defaults (inertial), 1: TPHL=0, 2: legacy MODE=0, 3: INIT=0.
// Directed tasks check timing against fixed values; the random task checks all
// instances against an edge-level behavioural model of the cell.

module tb_stand_cell_array;

    logic       U;
    logic       RESET;
    logic [7:0] D;
    logic       CLRGLITCH;

    logic [7:0] q_o [4];
    logic [7:0] b_o [4];
    logic [7:0] g_o [4];

    int errors;
    int checks;

    stand_cell_array dut_a (
        .U(U), .RESET(RESET), .D(D), .CLRGLITCH(CLRGLITCH),
        .Q(q_o[0]), .BUSY(b_o[0]), .GLITCH(g_o[0])
    );

    stand_cell_array #(.TPHL(0)) dut_z (
        .U(U), .RESET(RESET), .D(D), .CLRGLITCH(CLRGLITCH),
        .Q(q_o[1]), .BUSY(b_o[1]), .GLITCH(g_o[1])
    );

    stand_cell_array #(.MODE(1'b0)) dut_l (
        .U(U), .RESET(RESET), .D(D), .CLRGLITCH(CLRGLITCH),
        .Q(q_o[2]), .BUSY(b_o[2]), .GLITCH(g_o[2])
    );

    stand_cell_array #(.INIT(8'h00)) dut_n (
        .U(U), .RESET(RESET), .D(D), .CLRGLITCH(CLRGLITCH),
        .Q(q_o[3]), .BUSY(b_o[3]), .GLITCH(g_o[3])
    );

    initial U = 1'b0;
    always #5 U = ~U;

    // ------------------------------------------------------------------
    // Behavioural model. Inertial: count consecutive edges whose target
    // differs from Q; the (delay+1)-th commits, an early return is a glitch.
    // Legacy: Q follows ~T until T has been sampled for more than delay edges.
    // ------------------------------------------------------------------
    int tphl_c [4] = '{7, 0, 7, 7};
    bit mode_c [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit init_c [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    bit mq  [4][8];
    bit mb  [4][8];
    bit mg  [4][8];
    bit lt  [4][8];
    int run [4][8];
    bit mt;
    int md;

    always @(posedge U) begin
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 8; c++) begin
                mt = ~D[c];
                md = mt ? 31 : tphl_c[k];
                if (RESET) begin
                    mq[k][c]  = init_c[k];
                    mb[k][c]  = 1'b0;
                    mg[k][c]  = 1'b0;
                    run[k][c] = 0;
                end else if (mode_c[k]) begin
                    if (CLRGLITCH) mg[k][c] = 1'b0;
                    if (mt == mq[k][c]) begin
                        if (run[k][c] != 0) mg[k][c] = 1'b1;
                        run[k][c] = 0;
                    end else begin
                        run[k][c] = run[k][c] + 1;
                        if (run[k][c] == md + 1) begin
                            mq[k][c]  = mt;
                            run[k][c] = 0;
                        end
                    end
                    mb[k][c] = (run[k][c] != 0);
                end else begin
                    if (run[k][c] == 0 || mt != lt[k][c]) run[k][c] = 1;
                    else if (run[k][c] < 1000) run[k][c] = run[k][c] + 1;
                    lt[k][c] = mt;
                    mq[k][c] = (run[k][c] <= md) ? ~mt : mt;
                    mb[k][c] = (run[k][c] >= 1) && (run[k][c] < md);
                    mg[k][c] = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge U);
        @(negedge U);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        RESET = 1'b1; D = 8'hFF; CLRGLITCH = 1'b0;
        step(); step();
        checks++; if (q_o[0] !== 8'hFF) begin errors++; $display("FAIL reset_q: got %h want %h", q_o[0], 8'hFF); end
        checks++; if (b_o[0] !== 8'h00) begin errors++; $display("FAIL reset_busy: got %h want %h", b_o[0], 8'h00); end
        checks++; if (g_o[0] !== 8'h00) begin errors++; $display("FAIL reset_glitch: got %h want %h", g_o[0], 8'h00); end
        checks++; if (q_o[3] !== 8'h00) begin errors++; $display("FAIL reset_q_init0: got %h want %h", q_o[3], 8'h00); end
        RESET = 1'b0; D = 8'h00;
        for (int e = 1; e <= 2; e++) begin
            step();
            checks++; if (q_o[0] !== 8'hFF) begin errors++; $display("FAIL release_q e%0d: got %h want %h", e, q_o[0], 8'hFF); end
            checks++; if (b_o[0] !== 8'h00) begin errors++; $display("FAIL release_busy e%0d: got %h want %h", e, b_o[0], 8'h00); end
        end
    endtask

    task automatic test_fall_timing();
        D = 8'h01;
        for (int e = 1; e <= 7; e++) begin
            step();
            checks++; if (q_o[0] !== 8'hFF) begin errors++; $display("FAIL fall_q e%0d: got %h want %h", e, q_o[0], 8'hFF); end
            checks++; if (b_o[0] !== 8'h01) begin errors++; $display("FAIL fall_busy e%0d: got %h want %h", e, b_o[0], 8'h01); end
        end
        step();
        checks++; if (q_o[0] !== 8'hFE) begin errors++; $display("FAIL fall_q e8: got %h want %h", q_o[0], 8'hFE); end
        checks++; if (b_o[0] !== 8'h00) begin errors++; $display("FAIL fall_busy e8: got %h want %h", b_o[0], 8'h00); end
    endtask

    task automatic test_rise_timing();
        D = 8'h00;
        for (int e = 1; e <= 31; e++) begin
            step();
            checks++; if (q_o[0] !== 8'hFE) begin errors++; $display("FAIL rise_q e%0d: got %h want %h", e, q_o[0], 8'hFE); end
            checks++; if (b_o[0] !== 8'h01) begin errors++; $display("FAIL rise_busy e%0d: got %h want %h", e, b_o[0], 8'h01); end
        end
        step();
        checks++; if (q_o[0] !== 8'hFF) begin errors++; $display("FAIL rise_q e32: got %h want %h", q_o[0], 8'hFF); end
        checks++; if (b_o[0] !== 8'h00) begin errors++; $display("FAIL rise_busy e32: got %h want %h", b_o[0], 8'h00); end
    endtask

    task automatic test_tphl_zero();
        D = 8'h01;
        step();
        checks++; if (q_o[1] !== 8'hFE) begin errors++; $display("FAIL tphl0_q: got %h want %h", q_o[1], 8'hFE); end
        checks++; if (b_o[1] !== 8'h00) begin errors++; $display("FAIL tphl0_busy: got %h want %h", b_o[1], 8'h00); end
        checks++; if (q_o[0] !== 8'hFF) begin errors++; $display("FAIL tphl7_still_q: got %h want %h", q_o[0], 8'hFF); end
        repeat (7) step();
        checks++; if (q_o[0] !== 8'hFE) begin errors++; $display("FAIL tphl7_q: got %h want %h", q_o[0], 8'hFE); end
        D = 8'h00;
        repeat (32) step();
        checks++; if (q_o[0] !== 8'hFF) begin errors++; $display("FAIL restore_q_a: got %h want %h", q_o[0], 8'hFF); end
        checks++; if (q_o[1] !== 8'hFF) begin errors++; $display("FAIL restore_q_z: got %h want %h", q_o[1], 8'hFF); end
    endtask

    task automatic test_glitch();
        D = 8'h02;
        for (int e = 1; e <= 5; e++) begin
            step();
            checks++; if (q_o[0] !== 8'hFF) begin errors++; $display("FAIL glitch_q e%0d: got %h want %h", e, q_o[0], 8'hFF); end
            checks++; if (b_o[0] !== 8'h02) begin errors++; $display("FAIL glitch_busy e%0d: got %h want %h", e, b_o[0], 8'h02); end
            checks++; if (g_o[0] !== 8'h00) begin errors++; $display("FAIL glitch_early e%0d: got %h want %h", e, g_o[0], 8'h00); end
        end
        D = 8'h00;
        step();
        checks++; if (q_o[0] !== 8'hFF) begin errors++; $display("FAIL glitch_q e6: got %h want %h", q_o[0], 8'hFF); end
        checks++; if (g_o[0] !== 8'h02) begin errors++; $display("FAIL glitch_set: got %h want %h", g_o[0], 8'h02); end
        checks++; if (b_o[0] !== 8'h00) begin errors++; $display("FAIL glitch_busy e6: got %h want %h", b_o[0], 8'h00); end
        CLRGLITCH = 1'b1;
        step();
        CLRGLITCH = 1'b0;
        checks++; if (g_o[0] !== 8'h00) begin errors++; $display("FAIL glitch_clear: got %h want %h", g_o[0], 8'h00); end
    endtask

    task automatic test_clr_coincident();
        D = 8'h02;
        repeat (3) step();
        D = 8'h04;
        step();
        checks++; if (g_o[0] !== 8'h02) begin errors++; $display("FAIL coin_pre_glitch: got %h want %h", g_o[0], 8'h02); end
        checks++; if (b_o[0] !== 8'h04) begin errors++; $display("FAIL coin_pre_busy: got %h want %h", b_o[0], 8'h04); end
        step(); step();
        D = 8'h00; CLRGLITCH = 1'b1;
        step();
        CLRGLITCH = 1'b0;
        checks++; if (g_o[0] !== 8'h04) begin errors++; $display("FAIL coin_set_wins: got %h want %h", g_o[0], 8'h04); end
        checks++; if (q_o[0] !== 8'hFF) begin errors++; $display("FAIL coin_q: got %h want %h", q_o[0], 8'hFF); end
        CLRGLITCH = 1'b1;
        step();
        CLRGLITCH = 1'b0;
        checks++; if (g_o[0] !== 8'h00) begin errors++; $display("FAIL coin_clear: got %h want %h", g_o[0], 8'h00); end
    endtask

    task automatic test_legacy();
        logic exp_b;
        D = 8'h08;
        repeat (40) step();
        checks++; if (q_o[2][3] !== 1'b0) begin errors++; $display("FAIL legacy_settled: got %b want %b", q_o[2][3], 1'b0); end
        D = 8'h00;
        for (int e = 1; e <= 3; e++) begin
            step();
            checks++; if (q_o[2][3] !== 1'b0) begin errors++; $display("FAIL legacy_low e%0d: got %b want %b", e, q_o[2][3], 1'b0); end
        end
        D = 8'h08;
        for (int e = 1; e <= 7; e++) begin
            step();
            exp_b = (e < 7);
            checks++; if (q_o[2][3] !== 1'b1) begin errors++; $display("FAIL legacy_pulse e%0d: got %b want %b", e, q_o[2][3], 1'b1); end
            checks++; if (b_o[2][3] !== exp_b) begin errors++; $display("FAIL legacy_busy e%0d: got %b want %b", e, b_o[2][3], exp_b); end
            checks++; if (g_o[2] !== 8'h00) begin errors++; $display("FAIL legacy_glitch e%0d: got %h want %h", e, g_o[2], 8'h00); end
        end
        step();
        checks++; if (q_o[2][3] !== 1'b0) begin errors++; $display("FAIL legacy_end: got %b want %b", q_o[2][3], 1'b0); end
        D = 8'h00;
    endtask

    task automatic test_reset_midcount();
        D = 8'h01;
        repeat (8) step();
        checks++; if (q_o[0][0] !== 1'b0) begin errors++; $display("FAIL mid_setup_q: got %b want %b", q_o[0][0], 1'b0); end
        D = 8'h00;
        repeat (3) step();
        checks++; if (b_o[0][0] !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want %b", b_o[0][0], 1'b1); end
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        checks++; if (q_o[0] !== 8'hFF) begin errors++; $display("FAIL mid_reset_q: got %h want %h", q_o[0], 8'hFF); end
        checks++; if (b_o[0] !== 8'h00) begin errors++; $display("FAIL mid_reset_busy: got %h want %h", b_o[0], 8'h00); end
        checks++; if (g_o[0] !== 8'h00) begin errors++; $display("FAIL mid_reset_glitch: got %h want %h", g_o[0], 8'h00); end
        checks++; if (q_o[3] !== 8'h00) begin errors++; $display("FAIL mid_reset_q_init0: got %h want %h", q_o[3], 8'h00); end
        for (int e = 1; e <= 31; e++) begin
            step();
            checks++; if (q_o[3] !== 8'h00) begin errors++; $display("FAIL init0_q e%0d: got %h want %h", e, q_o[3], 8'h00); end
            checks++; if (b_o[3] !== 8'hFF) begin errors++; $display("FAIL init0_busy e%0d: got %h want %h", e, b_o[3], 8'hFF); end
            if (e == 1) begin
                checks++; if (q_o[0] !== 8'hFF) begin errors++; $display("FAIL mid_release_q: got %h want %h", q_o[0], 8'hFF); end
                checks++; if (b_o[0] !== 8'h00) begin errors++; $display("FAIL mid_release_busy: got %h want %h", b_o[0], 8'h00); end
            end
        end
        step();
        checks++; if (q_o[3] !== 8'hFF) begin errors++; $display("FAIL init0_rise: got %h want %h", q_o[3], 8'hFF); end
        checks++; if (b_o[3] !== 8'h00) begin errors++; $display("FAIL init0_busy_done: got %h want %h", b_o[3], 8'h00); end
    endtask

    task automatic test_random();
        logic [7:0] eq, eb, eg;
        RESET = 1'b1; CLRGLITCH = 1'b0;
        step();
        RESET = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 8; c++) begin
                if ($urandom_range(0, 29) == 0) D[c] = ~D[c];
            end
            CLRGLITCH = ($urandom_range(0, 19) == 0);
            RESET     = ($urandom_range(0, 499) == 0);
            step();
            for (int k = 0; k < 4; k++) begin
                for (int c = 0; c < 8; c++) begin
                    eq[c] = mq[k][c];
                    eb[c] = mb[k][c];
                    eg[c] = mg[k][c];
                end
                checks++; if (q_o[k] !== eq) begin errors++; $display("FAIL rand_q inst%0d cyc%0d: got %h want %h", k, n, q_o[k], eq); end
                checks++; if (b_o[k] !== eb) begin errors++; $display("FAIL rand_busy inst%0d cyc%0d: got %h want %h", k, n, b_o[k], eb); end
                checks++; if (g_o[k] !== eg) begin errors++; $display("FAIL rand_glitch inst%0d cyc%0d: got %h want %h", k, n, g_o[k], eg); end
            end
        end
        RESET = 1'b0; CLRGLITCH = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        RESET = 1'b1;
        D = 8'hFF;
        CLRGLITCH = 1'b0;
        test_reset();
        test_fall_timing();
        test_rise_timing();
        test_tphl_zero();
        test_glitch();
        test_clr_coincident();
        test_legacy();
        test_reset_midcount();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stand_cell_array.md
Name: stand_cell_array

Overview:
- Parametrised, multi-channel clocked model of a discrete standard logic cell with asymmetric propagation delay.
- Sampled on the fast simulation clock U.
- Each channel delays, and optionally inverts, its D input by separate high-to-low and low-to-high cycle counts.
- Two modes:
  - legacy mode: the existing single-cell response, cycle-exact.
  - inertial mode: rejects short pulses and flags them.

Parameters:
- WIDTH, 8: number of independent channels.
- TPHL, 7: U cycles of delay for an output falling transition (7 = 140 ns at 50 MHz).
- TPLH, 31: U cycles of delay for an output rising transition (31 = 620 ns).
- INVERT, 1: 1 = output is the delayed ~D (standard inverting cell); 0 = delayed D (buffer).
- MODE, 1: 0 = legacy response; 1 = inertial response.
- INIT, {WIDTH{1'b1}}: Q value loaded on reset.

Ports:
- U  input  1  clock; all state updates on posedge U.
- RESET  input  1  synchronous, active-high reset, sampled on posedge U.
- D  input  WIDTH  channel inputs, sampled on posedge U.
- CLRGLITCH  input  1  synchronous clear of all GLITCH bits.
- Q  output  WIDTH  delayed, optionally inverted, outputs (registered).
- BUSY  output  WIDTH  channel delay counter is running (decoded from registered state).
- GLITCH  output  WIDTH  sticky: a pulse shorter than the delay was rejected (registered).

Behaviour:
- One clock, U. Reset is synchronous and active-high; RESET dominates every other input on the same edge.
- Reset values: Q=INIT, all counters=0, BUSY=0, GLITCH=0.
- Per-channel target T = D[i] ^ INVERT. Delay select: T=0 uses TPHL; T=1 uses TPLH.
- Counter width CW = max(1, $clog2(max(TPHL,TPLH)+1)).
- Counters saturate at their delay value and never wrap.
- Channels are fully independent; no cross-channel interaction.
- Inertial mode (MODE=1), per edge, one counter cnt per channel:
  - T==Q and cnt==0: hold, nothing changes.
  - T==Q and cnt!=0 (pulse shorter than delay): cnt<=0, GLITCH[i]<=1, Q unchanged.
  - T!=Q and cnt!=delay(T): cnt<=cnt+1, Q unchanged.
  - T!=Q and cnt==delay(T): Q<=T, cnt<=0.
  - Latency: Q changes on the (delay+1)-th consecutive edge sampling the new T.
  - Delay 0 gives 1-edge latency.
- BUSY[i] = (cnt!=0).
- Legacy mode (MODE=0), two counters per channel, hc (TPHL side) and lc (TPLH side):
  - T=0: lc<=0. If hc!=TPHL: Q<=1, hc<=hc+1; else Q<=0.
  - T=1: hc<=0. If lc!=TPLH: Q<=0, lc<=lc+1; else Q<=1.
  - A short pulse produces the full opposite-level excursion. This is intentional legacy behaviour.
  - GLITCH is held at 0.
  - BUSY[i] = active-side counter not yet saturated.
- GLITCH clear: CLRGLITCH clears all GLITCH bits on the edge. If a glitch is detected on the same edge, the set wins for that channel.
- Reset mid-count: counters are discarded and Q=INIT. A held input then needs a full delay+1 edges from the first post-reset edge.
- Static input at reset release: if T!=INIT, the channel starts counting on the first edge after RESET deasserts.
- Outputs never change combinationally from D.

Test Plan:
- Reset: RESET=1 for 2 edges with D=8'hFF → Q=8'hFF, BUSY=0, GLITCH=0. Release with D=0 → no Q change, BUSY stays 0.
- Fall timing (defaults): D[0] 0→1 held, Q[0]=1 → BUSY[0]=1 after edges 1..7; Q[0]=0 after edge 8; BUSY[0]=0 after edge 8. Other channels unchanged.
- Rise timing: D[0] 1→0 held → Q[0] stays 0 through edge 31, becomes 1 after edge 32. Repeat with TPHL=0 → fall after edge 1.
- Glitch rejection (MODE=1): Q[1]=1, D[1] high for 5 edges then low → Q[1] stays 1 throughout; GLITCH[1]=1 after edge 6. CLRGLITCH pulse → GLITCH=0 next edge. CLRGLITCH coincident with a new glitch on ch2 → GLITCH[2]=1.
- Legacy (MODE=0): D[3] high long (Q[3]=0), then low 3 edges, then high → Q[3]=0 for those 3 edges, Q[3]=1 for next 7 edges, then 0. GLITCH stays 0.
- Reset mid-count: D[0] held 0 from Q=0 state, RESET asserted at edge 4 then released → Q=INIT=1, BUSY=0. With INIT=0, Q[0] rises exactly 32 edges after release.
